// File: rtl/e1b_code_loader.sv
// E1B spreading-code loader: copies a streamed code of len words into BRAM,
// tracking an XOR checksum and flagging bad lengths or aborted loads.
module e1b_code_loader #(
    parameter int E1B_CODELEN  = 4092,
    parameter int E1B_CODEBITS = 12,
    parameter int DATA_W       = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [E1B_CODEBITS-1:0] len,
    input  logic                    s_valid,
    input  logic [DATA_W-1:0]       s_data,
    output logic                    s_ready,
    output logic                    mem_we,
    output logic [E1B_CODEBITS-1:0] mem_addr,
    output logic [DATA_W-1:0]       mem_din,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    code_valid,
    output logic [DATA_W-1:0]       chk
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [31:0] CODELEN_U = E1B_CODELEN;

    state_t                  state;
    logic [E1B_CODEBITS-1:0] count;
    logic [E1B_CODEBITS-1:0] last_idx;
    logic                    len_ok;
    logic                    xfer;

    assign len_ok  = (len != '0) && (32'(len) <= CODELEN_U);
    // Abort and reset both close the stream in the same cycle they are seen.
    assign s_ready = (state == LOAD) && !abort && !rst;
    assign xfer    = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            last_idx   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            code_valid <= 1'b0;
            chk        <= '0;
        end else begin
            mem_we <= xfer;
            done   <= 1'b0;
            if (xfer) begin
                mem_addr <= count;
                mem_din  <= s_data;
                chk      <= chk ^ s_data;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        code_valid <= 1'b0;
                        if (len_ok) begin
                            last_idx <= len - E1B_CODEBITS'(1);
                            count    <= '0;
                            chk      <= '0;
                            err      <= 1'b0;
                            busy     <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        err        <= 1'b1;
                        code_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (xfer) begin
                        // count parks on the last index so it never passes len-1
                        if (count == last_idx) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            count <= count + E1B_CODEBITS'(1);
                        end
                    end
                end
                DONE: begin
                    code_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e1b_code_loader.sv
// Directed self-checking bench for e1b_code_loader; writes are logged by a
// posedge monitor and compared against hand-computed expectations.
module tb_e1b_code_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] len = '0;
    logic        s_valid = 1'b0;
    logic [11:0] s_data = '0;
    logic        s_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [11:0] mem_din;
    logic        busy;
    logic        done;
    logic        err;
    logic        code_valid;
    logic [11:0] chk;

    int checks = 0;
    int errors = 0;

    logic [11:0] wr_addr[$];
    logic [11:0] wr_data[$];
    int          done_cnt = 0;
    logic [11:0] exp_mem[0:4091];

    e1b_code_loader #(
        .E1B_CODELEN (4092),
        .E1B_CODEBITS(12),
        .DATA_W      (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .len       (len),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .code_valid(code_valid),
        .chk       (chk)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_din);
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        @(negedge clk); rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: actual %b required 0", s_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: actual %b required 0", mem_we); end
        checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL reset_mem_addr: actual %h required 000", mem_addr); end
        checks++; if (mem_din !== 12'h000) begin errors++; $display("FAIL reset_mem_din: actual %h required 000", mem_din); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: actual %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: actual %b required 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: actual %b required 0", err); end
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_code_valid: actual %b required 0", code_valid); end
        checks++; if (chk !== 12'h000) begin errors++; $display("FAIL reset_chk: actual %h required 000", chk); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int base;
        base = wr_addr.size();
        @(negedge clk); start = 1'b1; len = 12'd4;
        @(negedge clk); start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: actual %b required 1", busy); end
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 12'(1 << i);
            #1;
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL basic_s_ready[%0d]: actual %b required 1", i, s_ready); end
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: actual %b required 1", done); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL basic_final_we: actual %b required 1", mem_we); end
        checks++; if (mem_addr !== 12'd3) begin errors++; $display("FAIL basic_final_addr: actual %0d required 3", mem_addr); end
        checks++; if (mem_din !== 12'h008) begin errors++; $display("FAIL basic_final_din: actual %h required 008", mem_din); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: actual %b required 0", busy); end
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL basic_cv_early: actual %b required 0", code_valid); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: actual %b required 0", done); end
        checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL basic_code_valid: actual %b required 1", code_valid); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL basic_we_after: actual %b required 0", mem_we); end
        checks++; if (chk !== 12'h00F) begin errors++; $display("FAIL basic_chk: actual %h required 00f", chk); end
        checks++; if (wr_addr.size() - base !== 4) begin errors++; $display("FAIL basic_write_count: actual %0d required 4", wr_addr.size() - base); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (wr_addr[base+i] !== 12'(i) || wr_data[base+i] !== 12'(1 << i)) begin
                errors++; $display("FAIL basic_write[%0d]: actual addr %0d data %h required addr %0d data %h",
                                   i, wr_addr[base+i], wr_data[base+i], i, 12'(1 << i));
            end
        end
    endtask

    task automatic test_bad_len;
        logic [11:0] bad [2];
        int base;
        bad[0] = 12'd0; bad[1] = 12'd4093;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            base = wr_addr.size();
            @(negedge clk); start = 1'b1; len = bad[k]; s_valid = 1'b1; s_data = 12'hABC;
            @(negedge clk); start = 1'b0;
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL badlen%0d_err: actual %b required 1", bad[k], err); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badlen%0d_busy: actual %b required 0", bad[k], busy); end
            checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL badlen%0d_cv: actual %b required 0", bad[k], code_valid); end
            repeat (3) @(negedge clk);
            s_valid = 1'b0;
            checks++; if (wr_addr.size() - base !== 0) begin errors++; $display("FAIL badlen%0d_writes: actual %0d required 0", bad[k], wr_addr.size() - base); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badlen%0d_busy_hold: actual %b required 0", bad[k], busy); end
        end
    endtask

    task automatic test_abort;
        int base;
        base = wr_addr.size();
        @(negedge clk); start = 1'b1; len = 12'd8;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 12'(12'h100 + i);
            @(negedge clk);
        end
        abort = 1'b1; s_valid = 1'b1; s_data = 12'h1FF;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL abort_s_ready: actual %b required 0", s_ready); end
        @(negedge clk); abort = 1'b0; s_valid = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL abort_err: actual %b required 1", err); end
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL abort_cv: actual %b required 0", code_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: actual %b required 0", busy); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_we: actual %b required 0", mem_we); end
        repeat (2) @(negedge clk);
        checks++; if (wr_addr.size() - base !== 3) begin errors++; $display("FAIL abort_write_count: actual %0d required 3", wr_addr.size() - base); end
        else for (int i = 0; i < 3; i++) begin
            checks++; if (wr_addr[base+i] !== 12'(i) || wr_data[base+i] !== 12'(12'h100 + i)) begin
                errors++; $display("FAIL abort_write[%0d]: actual addr %0d data %h required addr %0d data %h",
                                   i, wr_addr[base+i], wr_data[base+i], i, 12'(12'h100 + i));
            end
        end
    endtask

    task automatic test_restart_in_load;
        int base;
        base = wr_addr.size();
        @(negedge clk); start = 1'b1; len = 12'd3;
        @(negedge clk); start = 1'b0; s_valid = 1'b1; s_data = 12'h123;
        @(negedge clk); s_valid = 1'b0; start = 1'b1; len = 12'd5;
        @(negedge clk); start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: actual %b required 1", busy); end
        s_valid = 1'b1; s_data = 12'h456;
        @(negedge clk); s_data = 12'h789;
        @(negedge clk); s_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done: actual %b required 1", done); end
        checks++; if (mem_addr !== 12'd2) begin errors++; $display("FAIL restart_last_addr: actual %0d required 2", mem_addr); end
        checks++; if (chk !== 12'h2FC) begin errors++; $display("FAIL restart_chk: actual %h required 2fc", chk); end
        @(negedge clk);
        checks++; if (wr_addr.size() - base !== 3) begin errors++; $display("FAIL restart_write_count: actual %0d required 3", wr_addr.size() - base); end
        else for (int i = 0; i < 3; i++) begin
            checks++; if (wr_addr[base+i] !== 12'(i)) begin errors++; $display("FAIL restart_addr[%0d]: actual %0d required %0d", i, wr_addr[base+i], i); end
        end
    endtask

    task automatic test_reset_mid_load;
        int base;
        @(negedge clk); start = 1'b1; len = 12'd20;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = 12'(i + 1);
            @(negedge clk);
        end
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rstmid_s_ready: actual %b required 0", s_ready); end
        @(negedge clk); rst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        checks++; if ({mem_we, busy, done, err, code_valid} !== 5'b0) begin
            errors++; $display("FAIL rstmid_flags: actual we/busy/done/err/cv %b required 00000", {mem_we, busy, done, err, code_valid}); end
        checks++; if ({mem_addr, mem_din, chk} !== 36'h0) begin
            errors++; $display("FAIL rstmid_data: actual addr %h din %h chk %h required 000 000 000", mem_addr, mem_din, chk); end
        base = wr_addr.size();
        @(negedge clk); start = 1'b1; len = 12'd2;
        @(negedge clk); start = 1'b0; s_valid = 1'b1; s_data = 12'h0AA;
        @(negedge clk); s_data = 12'h055;
        @(negedge clk); s_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done: actual %b required 1", done); end
        @(negedge clk);
        checks++; if (chk !== 12'h0FF) begin errors++; $display("FAIL rstmid_chk: actual %h required 0ff", chk); end
        checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL rstmid_cv: actual %b required 1", code_valid); end
        checks++; if (wr_addr.size() - base !== 2) begin errors++; $display("FAIL rstmid_write_count: actual %0d required 2", wr_addr.size() - base); end
        else begin
            checks++; if (wr_addr[base+1] !== 12'd1 || wr_data[base+1] !== 12'h055) begin
                errors++; $display("FAIL rstmid_write1: actual addr %0d data %h required addr 1 data 055", wr_addr[base+1], wr_data[base+1]); end
        end
    endtask

    task automatic test_full_load;
        int          base;
        int          dbase;
        int          budget;
        logic [11:0] exp_chk;
        bit          timed_out;
        base = wr_addr.size();
        dbase = done_cnt;
        exp_chk = '0;
        timed_out = 1'b0;
        budget = 30000;
        for (int i = 0; i < 4092; i++) begin
            exp_mem[i] = 12'($urandom);
            exp_chk = exp_chk ^ exp_mem[i];
        end
        @(negedge clk); start = 1'b1; len = 12'd4092;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 4092 && !timed_out; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
            s_valid = 1'b1; s_data = exp_mem[i];
            #1;
            while (s_ready !== 1'b1 && budget > 0) begin
                @(negedge clk); #1; budget--;
            end
            if (budget <= 0) timed_out = 1'b1;
            else @(negedge clk);
        end
        checks++; if (timed_out) begin errors++; $display("FAIL full_timeout: actual s_ready stuck low, required word accepted"); end
        s_valid = 1'b1; s_data = 12'hFFF;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready_done: actual %b required 0", s_ready); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done: actual %b required 1", done); end
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (done_cnt - dbase !== 1) begin errors++; $display("FAIL full_done_count: actual %0d required 1", done_cnt - dbase); end
        checks++; if (chk !== exp_chk) begin errors++; $display("FAIL full_chk: actual %h required %h", chk, exp_chk); end
        checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL full_cv: actual %b required 1", code_valid); end
        checks++; if (wr_addr.size() - base !== 4092) begin errors++; $display("FAIL full_write_count: actual %0d required 4092", wr_addr.size() - base); end
        else for (int i = 0; i < 4092; i++) begin
            checks++; if (wr_addr[base+i] !== 12'(i) || wr_data[base+i] !== exp_mem[i]) begin
                errors++; $display("FAIL full_write[%0d]: actual addr %0d data %h required addr %0d data %h",
                                   i, wr_addr[base+i], wr_data[base+i], i, exp_mem[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_bad_len();
        do_reset();
        test_restart_in_load();
        test_reset_mid_load();
        test_full_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/e1b_code_loader.md
E1B_CODE_LOADER -- requirements
Module: e1b_code_loader

Interface
REQ-001 SHALL have parameter E1B_CODELEN, default 4092, meaning the number of code words the BRAM holds.
REQ-002 SHALL have parameter E1B_CODEBITS, default 12, meaning the code address and length width.
REQ-003 SHALL have parameter DATA_W, default 12, meaning the code word width.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle pulse that begins a load.
REQ-007 SHALL have port abort, input, 1, cancels a load in progress.
REQ-008 SHALL have port len, input, E1B_CODEBITS, word count sampled on start.
REQ-009 SHALL have port s_valid, input, 1, stream word valid.
REQ-010 SHALL have port s_data, input, DATA_W, stream word.
REQ-011 SHALL have port s_ready, output, 1, stream ready.
REQ-012 SHALL have port mem_we, output, 1, BRAM write enable.
REQ-013 SHALL have port mem_addr, output, E1B_CODEBITS, BRAM write address.
REQ-014 SHALL have port mem_din, output, DATA_W, BRAM write data.
REQ-015 SHALL have port busy, output, 1, high while in state LOAD.
REQ-016 SHALL have port done, output, 1, single-cycle pulse on successful completion.
REQ-017 SHALL have port err, output, 1, sticky error flag.
REQ-018 SHALL have port code_valid, output, 1, high when the BRAM holds a complete code.
REQ-019 SHALL have port chk, output, DATA_W, XOR checksum of the accepted words.

Function
REQ-020 SHALL implement exactly three states: IDLE, LOAD and DONE.
REQ-021 SHALL check start in IDLE: when 1 <= len <= E1B_CODELEN, latch len, clear count, chk and err, drop code_valid, and enter LOAD on the next cycle.
REQ-022 SHALL, on start in IDLE with len==0 or len>E1B_CODELEN, set err=1 and code_valid=0 and remain in IDLE.
REQ-023 SHALL ignore start while in LOAD or DONE.
REQ-024 SHALL drive s_ready combinationally as (state==LOAD) && !abort, so that no transfer occurs in an abort cycle.
REQ-025 SHALL define a transfer as s_valid && s_ready, and SHALL register mem_we=1, mem_addr=count and mem_din=s_data one cycle after each transfer (write latency 1).
REQ-026 SHALL hold mem_we=0 in every cycle not following a transfer, and SHALL keep mem_addr and mem_din at their last values.
REQ-027 SHALL update chk to chk XOR s_data on each transfer, registered, and SHALL hold chk after completion until the next valid start.
REQ-028 SHALL increment count by 1 per transfer and SHALL never let it exceed latched len-1; no wrap occurs.
REQ-029 SHALL enter DONE on the transfer where count==len-1, with s_ready=0 in DONE.
REQ-030 SHALL assert done for exactly the single DONE cycle, coincident with the final mem_we=1, then return to IDLE.
REQ-031 SHALL raise code_valid in the cycle after done and hold it until the next valid start, an abort, or reset.
REQ-032 SHALL respond to abort in LOAD by entering IDLE next cycle with err=1 and code_valid=0; any registered mem_we from the previous-cycle transfer still completes.
REQ-033 SHALL ignore abort in IDLE and DONE.
REQ-034 SHALL tolerate s_valid gaps of any length in LOAD with no timeout, busy remaining 1.

Reset
REQ-035 SHALL, on rst=1 at a clock edge, enter state IDLE regardless of current state, including mid-LOAD.
REQ-036 SHALL drive these outputs to 0 the cycle after reset: mem_we, mem_addr, mem_din, busy, done, err, code_valid, chk.
REQ-037 SHALL have rst take priority over start and abort in the same cycle.
REQ-038 SHALL hold s_ready=0 while rst=1.

Verification
REQ-039 SHALL cover: start with len=4, then words 0x001, 0x002, 0x004, 0x008 back-to-back -> mem_we on 4 consecutive cycles at addr 0..3, done on the addr-3 cycle, code_valid=1 on the next cycle, chk=0x00F.
REQ-040 SHALL cover: start with len=0, then separately len=4093 -> err=1, busy stays 0, no mem_we.
REQ-041 SHALL cover: len=8, abort after 3 transfers, with s_valid=1 in the abort cycle -> exactly 3 writes (addr 0..2), s_ready=0 in the abort cycle, err=1, code_valid=0.
REQ-042 SHALL cover: full load of len=4092 with random s_valid gaps -> 4092 writes at addr 0..4091 with no repeats, done pulsed once, chk equal to the XOR of all words.
REQ-043 SHALL cover: rst asserted mid-LOAD after 10 words -> all outputs 0 the next cycle; a new start with len=2 then completes normally.
REQ-044 SHALL cover: start pulsed again during LOAD -> ignored, with latched len and count unaffected.
